sram_block_reader: RTL and testbench
====================================

SRAM_BLOCK_READER -- requirements
Module: sram_block_reader

Interface
REQ-001 Parameter READ_LAT, default 2, meaning SRAM read latency in cycles that sram_read/sram_addr are held before sram_rdata is sampled; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a fetch job; sampled only in IDLE.
REQ-005 start_addr  input  16  byte address of first 128-bit block; bits [3:0] ignored (treated as 0).
REQ-006 num_blocks  input  8  number of 128-bit blocks to fetch; 0 means empty job.
REQ-007 busy  output  1  high from the cycle after accepted start until the cycle done pulses, inclusive.
REQ-008 done  output  1  one-cycle pulse when the job completes.
REQ-009 sram_read  output  1  SRAM read strobe, held high for READ_LAT cycles per block.
REQ-010 sram_addr  output  16  SRAM byte address, stable while sram_read is high.
REQ-011 sram_rdata  input  128  SRAM read data.
REQ-012 out_valid  output  1  out_data holds a valid block.
REQ-013 out_data  output  128  fetched block, stable while out_valid is high and out_ready is low.
REQ-014 out_ready  input  1  downstream accepts the block when high with out_valid.

Function
REQ-015 FSM states SHALL be IDLE, READ, HOLD, DONE.
REQ-016 IDLE: start=1 with num_blocks>0 latches aligned start_addr into the address counter and num_blocks into the remaining counter, goes to READ.
REQ-017 IDLE: start=1 with num_blocks=0 goes to DONE with no SRAM access.
REQ-018 READ: sram_read=1 and sram_addr=address counter for exactly READ_LAT cycles; on the last cycle sram_rdata is captured into out_data, out_valid set next cycle, state goes to HOLD.
REQ-019 HOLD: out_valid=1 until out_ready=1; on transfer, remaining decrements, address increments by 16 (modulo 2^16, 16'hFFF0 wraps to 16'h0000).
REQ-020 HOLD transfer with remaining>1 goes to READ in the next cycle; with remaining=1 goes to DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; busy is low the cycle after done.
REQ-022 At most one read outstanding; no new sram_read while out_valid is high.
REQ-023 start while not IDLE SHALL be ignored; start_addr/num_blocks changes after acceptance have no effect.
REQ-024 sram_read SHALL be low in IDLE, HOLD and DONE; sram_addr holds its last value there.
REQ-025 Throughput with out_ready tied high: one block per READ_LAT+1 cycles.

Reset
REQ-026 n_rst low SHALL immediately force IDLE and drive busy=0, done=0, sram_read=0, sram_addr=16'h0000, out_valid=0, out_data=128'h0, counters=0.
REQ-027 Reset mid-job abandons the job; no done pulse, no out_valid after release until a new start.

Structure
REQ-028 State enum and constant BLOCK_BYTES=16 SHALL live in a shared package sram_pkg, together with the 128-bit block typedef.
REQ-029 One sub-module, flex_counter, SHALL implement the READ_LAT latency counter; the rest is flat.

Verification
REQ-030 start_addr=0, num_blocks=3, SRAM preloaded with 0123456789ABCDEFFEDCBA9876543210 @0, all-F @16, AABBCCDDEEFF00998877665544332211 @32, out_ready=1 -> three blocks in that order, sram_addr 0,16,32, done once, busy low after.
REQ-031 num_blocks=1, out_ready low for 10 cycles -> out_valid held, out_data stable, no second sram_read; transfer on ready, then done.
REQ-032 start_addr=16'hFFF0, num_blocks=2 -> sram_addr 16'hFFF0 then 16'h0000.
REQ-033 num_blocks=0 -> done one cycle after start, sram_read never high, out_valid never high.
REQ-034 n_rst asserted during second READ of a 3-block job -> all outputs zero at once; no done; new job afterwards completes normally.
REQ-035 start pulsed again while busy with start_addr=32 -> ignored, original job addresses unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM block reader
package sram_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_t;

    function automatic logic [15:0] align_addr(input logic [15:0] addr);
        return addr & ~16'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with synchronous clear and rollover flag
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             count_enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/sram_block_reader.sv
// rtl/sram_block_reader.sv - fetches a run of 128-bit blocks from SRAM into a ready/valid output
module sram_block_reader
    import sram_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [15:0]  start_addr,
    input  logic [7:0]   num_blocks,
    output logic         busy,
    output logic         done,
    output logic         sram_read,
    output logic [15:0]  sram_addr,
    input  logic [127:0] sram_rdata,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready
);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sram_read_q, sram_read_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic        out_valid_q, out_valid_d;
    block_t      out_data_q, out_data_d;

    logic        in_read;
    logic        lat_last;
    logic [15:0] addr_next;

    assign in_read   = (state_q == READ);
    assign addr_next = addr_q + 16'(BLOCK_BYTES);

    flex_counter #(
        .WIDTH(4)
    ) u_lat_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .count_enable (in_read),
        .clear        (in_read && lat_last),
        .rollover_val (4'(READ_LAT - 1)),
        .rollover_flag(lat_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sram_read_d = sram_read_q;
        sram_addr_d = sram_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (num_blocks != 8'd0) begin
                        state_d     = READ;
                        addr_d      = align_addr(start_addr);
                        remaining_d = num_blocks;
                        sram_read_d = 1'b1;
                        sram_addr_d = align_addr(start_addr);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (lat_last) begin
                    sram_read_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = sram_rdata;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - 8'd1;
                    addr_d      = addr_next;
                    if (remaining_q > 8'd1) begin
                        state_d     = READ;
                        sram_read_d = 1'b1;
                        sram_addr_d = addr_next;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            remaining_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sram_read_q <= 1'b0;
            sram_addr_q <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sram_read_q <= sram_read_d;
            sram_addr_q <= sram_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_read = sram_read_q;
    assign sram_addr = sram_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sram_block_reader.sv
// tb/tb_sram_block_reader.sv - self-checking bench for sram_block_reader
module tb_sram_block_reader;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [15:0]  start_addr;
    logic [7:0]   num_blocks;
    logic         busy;
    logic         done;
    logic         sram_read;
    logic [15:0]  sram_addr;
    logic [127:0] sram_rdata;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] mem [4096];
    int           rd_cnt;

    logic [15:0]  addr_log [$];
    logic [127:0] data_log [$];
    int           viol = 0;
    int           done_cnt = 0;
    int           ov_seen = 0;
    logic         prev_rd = 1'b0;
    int           rd_run = 0;
    logic [15:0]  rd_addr = 16'h0;
    logic         prev_hold = 1'b0;
    logic [127:0] held_data = '0;

    always #5 clk = ~clk;

    sram_block_reader #(.READ_LAT(LAT)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .start_addr (start_addr),
        .num_blocks (num_blocks),
        .busy       (busy),
        .done       (done),
        .sram_read  (sram_read),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    // SRAM model: data is only meaningful once the strobe has been held LAT cycles
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rd_cnt <= 0;
        else        rd_cnt <= sram_read ? rd_cnt + 1 : 0;
    end
    assign sram_rdata = (sram_read && rd_cnt == LAT - 1) ? mem[sram_addr[15:4]] : {4{32'hDEADBEEF}};

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_rd   = 1'b0;
            prev_hold = 1'b0;
            rd_run    = 0;
        end else begin
            if (sram_read) begin
                if (!prev_rd) begin
                    addr_log.push_back(sram_addr);
                    rd_run = 1;
                end else begin
                    rd_run++;
                    if (sram_addr !== rd_addr) viol++;
                end
                rd_addr = sram_addr;
                if (out_valid) viol++;
            end else if (prev_rd && rd_run != LAT) begin
                viol++;
            end
            prev_rd = sram_read;
            if (prev_hold && out_valid && out_data !== held_data) viol++;
            prev_hold = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) data_log.push_back(out_data);
            if (out_valid) ov_seen++;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low ~10 cycles into the first hold
    task automatic run_job(input logic [15:0] a, input logic [7:0] n, input int mode, input bit poke);
        int          cyc;
        int          ab, db, dc, vb;
        logic [15:0] ea;
        ab = addr_log.size();
        db = data_log.size();
        dc = done_cnt;
        vb = viol;
        start      = 1'b1;
        start_addr = a;
        num_blocks = n;
        out_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
        tick();
        start      = 1'b0;
        start_addr = 16'($urandom);
        num_blocks = 8'($urandom);
        cyc = 1;
        check("busy_after_start", busy, 1);
        while (done !== 1'b1 && cyc < 4000) begin
            start = poke && (cyc == 2);
            if (start) begin
                start_addr = 16'd32;
                num_blocks = 8'd5;
            end
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            if (mode == 2) out_ready = (cyc >= LAT + 11);
            tick();
            cyc++;
            if (mode == 2 && cyc == LAT + 6) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_no_read", sram_read, 0);
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (mode == 0) check("job_latency", cyc, n * (LAT + 1) + 1);
        check("busy_at_done", busy, 1);
        tick();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("done_count", done_cnt - dc, 1);
        check("read_count", addr_log.size() - ab, n);
        check("block_count", data_log.size() - db, n);
        for (int i = 0; i < int'(n) && i < addr_log.size() - ab && i < data_log.size() - db; i++) begin
            ea = (a & 16'hFFF0) + 16'(i * 16);
            check("block_addr", addr_log[ab + i], ea);
            check("block_data", data_log[db + i], mem[ea[15:4]]);
        end
        check("protocol_clean", viol - vb, 0);
    endtask

    initial begin
        int ab, db, dc, ov;
        logic [127:0] w0, w2;
        n_rst      = 1'b0;
        start      = 1'b0;
        start_addr = 16'h0;
        num_blocks = 8'h0;
        out_ready  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        w0 = 128'h0123456789ABCDEFFEDCBA9876543210;
        w2 = 128'hAABBCCDDEEFF00998877665544332211;
        mem[0] = w0;
        mem[1] = {128{1'b1}};
        mem[2] = w2;

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sram_read", sram_read, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        n_rst = 1'b1;
        tick();

        db = data_log.size();
        ab = addr_log.size();
        run_job(16'h0000, 8'd3, 0, 1'b0);
        check("three_blk0", data_log[db], w0);
        check("three_blk1", data_log[db + 1], {128{1'b1}});
        check("three_blk2", data_log[db + 2], w2);
        check("three_addr2", addr_log[ab + 2], 16'd32);

        run_job(16'h0040, 8'd1, 2, 1'b0);

        ab = addr_log.size();
        run_job(16'hFFF0, 8'd2, 0, 1'b0);
        check("wrap_addr0", addr_log[ab], 16'hFFF0);
        check("wrap_addr1", addr_log[ab + 1], 16'h0000);

        ov = ov_seen;
        run_job(16'h1234, 8'd0, 0, 1'b0);
        check("empty_no_valid", ov_seen - ov, 0);

        run_job(16'h0100, 8'd2, 0, 1'b1);

        start      = 1'b1;
        start_addr = 16'h0000;
        num_blocks = 8'd3;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        repeat (LAT + 1) tick();
        check("second_read_strobe", sram_read, 1);
        check("second_read_addr", sram_addr, 16'd16);
        n_rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sram_read", sram_read, 0);
        check("midrst_sram_addr", sram_addr, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        tick();
        tick();
        n_rst = 1'b1;
        dc = done_cnt;
        ov = ov_seen;
        repeat (8) tick();
        check("postrst_no_done", done_cnt - dc, 0);
        check("postrst_no_valid", ov_seen - ov, 0);
        check("postrst_idle", busy, 0);
        run_job(16'h0020, 8'd3, 0, 1'b0);

        repeat (12) run_job(16'($urandom), 8'($urandom_range(0, 6)), int'($urandom_range(0, 1)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
